// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and load/store ports.
// Build option: define ARB_ROUND_ROBIN_EN to alternate the winner on collisions.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [BE_W-1:0]   dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic              mem_req_d;
    logic              mem_we_d;
    logic [BE_W-1:0]   mem_be_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              dm_wins;
    logic              gnt_hit;
    logic              rsp_hit;

    // Arbitration: who takes the memory when leaving IDLE
    always_comb begin
        dm_wins = dm_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req && dm_req) begin
            dm_wins = (last_owner_q == OWN_IF);
        end
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_be_d     = mem_be;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d   = REQ;
                    mem_req_d = 1'b1;
                    if (dm_wins) begin
                        owner_d     = OWN_DM;
                        mem_we_d    = dm_we;
                        mem_be_d    = dm_be;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        owner_d     = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                    last_owner_d = owner_d;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d   = RSP;
                    mem_req_d = 1'b0;
                end
            end
            RSP: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_req      <= mem_req_d;
            mem_we       <= mem_we_d;
            mem_be       <= mem_be_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
        end
    end

    // Handshake responses are steered straight through to the current owner
    assign gnt_hit   = mem_gnt && (state_q == REQ);
    assign rsp_hit   = mem_rvalid && (state_q == RSP);
    assign if_gnt    = gnt_hit && (owner_q == OWN_IF);
    assign dm_gnt    = gnt_hit && (owner_q == OWN_DM);
    assign if_rvalid = rsp_hit && (owner_q == OWN_IF);
    assign dm_rvalid = rsp_hit && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

`ifndef SYNTHESIS
    // A response after reset but before any new issue belongs to a discarded transaction
    logic issued_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= 1'b0;
        end else if (state_q == REQ) begin
            issued_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_rvalid && issued_q) begin
            assert (state_q == RSP)
            else $error("mem_rvalid received outside RSP state");
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default and round-robin builds).
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [BE_W-1:0]   dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        tick(); tick();
        @(negedge clk);
        n_chk++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem_outputs: got req=%b we=%b be=%h addr=%h wdata=%h want all 0", mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
        n_chk++; if ({if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata} !== '0) begin n_fail++; $display("FAIL reset_port_outputs: got if_gnt=%b if_rvalid=%b dm_gnt=%b dm_rvalid=%b want 0", if_gnt, if_rvalid, dm_gnt, dm_rvalid); end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after_release: mem_req=%b want 0", mem_req); end
    endtask

    task automatic test_single_fetch();
        tick();
        if_req = 1; if_addr = 32'h0000_0010;
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_cycle0_mem_req: got %b want 0", mem_req); end
        tick();
        mem_gnt = 1;
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_req: got %b want 1", mem_req); end
        n_chk++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b0, 4'hF, 32'h10, 32'h0}) begin n_fail++; $display("FAIL fetch_mem_attr: got we=%b be=%h addr=%h wdata=%h want 0/f/10/0", mem_we, mem_be, mem_addr, mem_wdata); end
        n_chk++; if ({if_gnt, dm_gnt} !== 2'b10) begin n_fail++; $display("FAIL fetch_gnt: got if_gnt=%b dm_gnt=%b want 1/0", if_gnt, dm_gnt); end
        tick();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0513;
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_dropped: got %b want 0", mem_req); end
        n_chk++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h0000_0513}) begin n_fail++; $display("FAIL fetch_rvalid: got rvalid=%b rdata=%h want 1/00000513", if_rvalid, if_rdata); end
        n_chk++; if ({dm_gnt, dm_rvalid, dm_rdata} !== '0) begin n_fail++; $display("FAIL fetch_dm_quiet: got dm_gnt=%b dm_rvalid=%b dm_rdata=%h want 0", dm_gnt, dm_rvalid, dm_rdata); end
        tick();
        mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        n_chk++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_rvalid_single: got %b want 0", if_rvalid); end
    endtask

    task automatic test_store();
        tick();
        dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        tick();
        for (int i = 0; i < 2; i++) begin
            mem_gnt = (i == 1);
            @(negedge clk);
            n_chk++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL store_mem_attr[%0d]: got req=%b we=%b be=%h addr=%h wdata=%h", i, mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
            n_chk++; if ({dm_gnt, if_gnt} !== {(i == 1), 1'b0}) begin n_fail++; $display("FAIL store_gnt[%0d]: got dm_gnt=%b if_gnt=%b want %b/0", i, dm_gnt, if_gnt, (i == 1)); end
            if (i == 0) tick();
        end
        tick();
        dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rvalid = 1;
        @(negedge clk);
        n_chk++; if ({dm_rvalid, if_rvalid} !== 2'b10) begin n_fail++; $display("FAIL store_ack: got dm_rvalid=%b if_rvalid=%b want 1/0", dm_rvalid, if_rvalid); end
        tick();
        mem_rvalid = 0;
    endtask

    task automatic test_collision();
        logic if_first;
`ifdef ARB_ROUND_ROBIN_EN
        if_first = 1'b1;
`else
        if_first = 1'b0;
`endif
        tick();
        if_req = 1; if_addr = 32'h20;
        dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h200;
        tick();
        mem_gnt = 1;
        @(negedge clk);
        n_chk++; if ({if_gnt, dm_gnt} !== {if_first, ~if_first}) begin n_fail++; $display("FAIL collide_first_gnt: got if_gnt=%b dm_gnt=%b want %b/%b", if_gnt, dm_gnt, if_first, ~if_first); end
        n_chk++; if (mem_addr !== (if_first ? 32'h20 : 32'h200)) begin n_fail++; $display("FAIL collide_first_addr: got %h", mem_addr); end
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111;
        if (if_first) if_req = 0; else dm_req = 0;
        @(negedge clk);
        n_chk++; if ({if_rvalid, dm_rvalid} !== {if_first, ~if_first}) begin n_fail++; $display("FAIL collide_first_rvalid: got if=%b dm=%b", if_rvalid, dm_rvalid); end
        tick();
        mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        n_chk++; if ({if_gnt, dm_gnt, mem_req} !== 3'b000) begin n_fail++; $display("FAIL collide_idle_gap: got if_gnt=%b dm_gnt=%b mem_req=%b want 0", if_gnt, dm_gnt, mem_req); end
        tick();
        mem_gnt = 1;
        @(negedge clk);
        n_chk++; if ({if_gnt, dm_gnt} !== {~if_first, if_first}) begin n_fail++; $display("FAIL collide_second_gnt: got if_gnt=%b dm_gnt=%b want %b/%b", if_gnt, dm_gnt, ~if_first, if_first); end
        n_chk++; if (mem_addr !== (if_first ? 32'h200 : 32'h20)) begin n_fail++; $display("FAIL collide_second_addr: got %h", mem_addr); end
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h2222_2222;
        if_req = 0; dm_req = 0;
        @(negedge clk);
        n_chk++; if ((if_first ? dm_rdata : if_rdata) !== 32'h2222_2222) begin n_fail++; $display("FAIL collide_second_rdata: got if=%h dm=%h want 22222222", if_rdata, dm_rdata); end
        tick();
        mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic test_wait_states();
        int gnt_cnt = 0;
        int rv_cnt  = 0;
        int dm_cnt  = 0;
        tick();
        if_req = 1; if_addr = 32'h40;
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_gnt = (i == 4);
            @(negedge clk);
            n_chk++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h40}) begin n_fail++; $display("FAIL wait_mem_stable[%0d]: got req=%b we=%b be=%h addr=%h", i, mem_req, mem_we, mem_be, mem_addr); end
            if (if_gnt) gnt_cnt++;
            if (dm_gnt || dm_rvalid) dm_cnt++;
            tick();
        end
        if_req = 0; mem_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = (i == 1);
            mem_rdata  = (i == 1) ? 32'hCAFE_F00D : '0;
            @(negedge clk);
            if (if_rvalid) begin
                rv_cnt++;
                n_chk++; if (if_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wait_rdata: got %h want cafef00d", if_rdata); end
            end
            if (dm_gnt || dm_rvalid) dm_cnt++;
            tick();
        end
        mem_rvalid = 0; mem_rdata = '0;
        n_chk++; if (gnt_cnt !== 1) begin n_fail++; $display("FAIL wait_gnt_pulses: got %0d want 1", gnt_cnt); end
        n_chk++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL wait_rvalid_pulses: got %0d want 1", rv_cnt); end
        n_chk++; if (dm_cnt !== 0) begin n_fail++; $display("FAIL wait_dm_pulses: got %0d want 0", dm_cnt); end
    endtask

    task automatic test_reset_mid_op();
        tick();
        dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h300;
        tick();
        mem_gnt = 1;
        tick();
        dm_req = 0; mem_gnt = 0;
        rst_n = 0;
        #1;
        n_chk++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL midrst_mem_cleared: got req=%b be=%h addr=%h want 0", mem_req, mem_be, mem_addr); end
        tick();
        rst_n = 1;
        tick();
        mem_rvalid = 1; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        n_chk++; if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata} !== '0) begin n_fail++; $display("FAIL midrst_stray_rvalid: got if_rvalid=%b dm_rvalid=%b dm_rdata=%h want 0", if_rvalid, dm_rvalid, dm_rdata); end
        tick();
        mem_rvalid = 0; mem_rdata = '0;
        if_req = 1; if_addr = 32'h80;
        tick();
        mem_gnt = 1;
        @(negedge clk);
        n_chk++; if ({mem_req, mem_addr, if_gnt} !== {1'b1, 32'h80, 1'b1}) begin n_fail++; $display("FAIL midrst_fresh_issue: got req=%b addr=%h if_gnt=%b want 1/80/1", mem_req, mem_addr, if_gnt); end
        tick();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h5;
        @(negedge clk);
        n_chk++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h5}) begin n_fail++; $display("FAIL midrst_fresh_rvalid: got %b/%h want 1/5", if_rvalid, if_rdata); end
        tick();
        mem_rvalid = 0; mem_rdata = '0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_collision();
        test_wait_states();
        test_reset_mid_op();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the rv32i instruction-fetch port and the load/store data port.
- Arbitrates between the two requesters, registers the winner's request, and issues it on a req/gnt/rvalid memory handshake.
- Routes the response back to the requester that issued it.
- Sits between the core and the memory model. One transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted
if_rvalid  out  1  fetch data valid
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_be  in  BE_W  store byte enables
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  data request accepted
dm_rvalid  out  1  load data valid / store acknowledge
dm_rdata  out  DATA_W  load data
mem_req  out  1  request to memory
mem_we  out  1  write enable to memory
mem_be  out  BE_W  byte enables to memory
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  memory response valid (loads and stores)
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. Reset forces IDLE, owner=IF, last_owner=IF and clears every registered mem_* output. All outputs read 0 during and after reset until a request arrives.
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: mem_req asserted, waiting for mem_gnt.
  - RSP: granted, waiting for mem_rvalid.
- IDLE transitions:
  - If if_req or dm_req is set, pick a winner (see arbitration).
  - Latch the winner's addr/we/be/wdata into registers and record owner.
  - Go to REQ. mem_req=1 from the next cycle.
  - A fetch always drives mem_we=0, mem_be=all-ones and mem_wdata=0.
- REQ transitions:
  - mem_req=1 and mem_* are held stable until mem_gnt.
  - On mem_gnt, the owner's gnt output is pulsed that same cycle (combinational from mem_gnt & state==REQ & owner). Then mem_req is dropped and the FSM goes to RSP.
  - The non-owner's gnt stays 0.
- RSP transitions:
  - On mem_rvalid, the owner's rvalid is pulsed that same cycle with rdata=mem_rdata.
  - Go to IDLE.
  - The non-owner's rdata is 0.
- Latency: with a zero-wait memory (gnt in the first REQ cycle, rvalid the cycle after gnt), req-to-gnt is 1 cycle and req-to-rvalid is 2 cycles. Back-to-back throughput is one transaction per 3 cycles.
- Arbitration (default build):
  - dm wins whenever dm_req=1, even if if_req=1 in the same cycle.
  - The fetch waits, holding if_req. No gnt is given to a requester without an issued transaction.
- Protocol rules:
  - The requester must hold req and attributes until gnt. Attributes are sampled only at IDLE->REQ.
  - If a requester drops req while in REQ, the issued transaction still completes and its rvalid is still delivered to the owner.
  - mem_rvalid outside RSP, and mem_rvalid in the same cycle as mem_gnt, are ignored; a simulation-only assertion flags them.
- Reset mid-operation: in-flight state is discarded immediately. A mem_rvalid arriving after reset deassertion while in IDLE is ignored.
- last_owner is updated at every IDLE->REQ transition.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both if_req and dm_req are set in IDLE, the requester that is not last_owner wins. A single requester always wins regardless of last_owner.
- Undefined: fixed data-port priority as above; last_owner is still maintained but unused.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0010, memory returns 0x0000_0513 with zero wait.
  -> mem_req at cycle 1, if_gnt at cycle 1, if_rvalid with if_rdata=0x0000_0513 at cycle 2, dm_* outputs stay 0.
- Store: dm_req=1, dm_we=1, dm_be=4'b0011, dm_addr=0x100, dm_wdata=0xDEAD_BEEF.
  -> mem_we=1, mem_be=4'b0011, mem_addr=0x100, mem_wdata=0xDEAD_BEEF until gnt; dm_rvalid pulse 1 cycle after gnt.
- Collision, default build: if_req and dm_req raised in the same cycle.
  -> load served first; fetch issued next IDLE; if_gnt arrives 3 cycles after dm_gnt.
- Collision, ARB_ROUND_ROBIN_EN build: last_owner=DM, both requesters held for 6 cycles.
  -> grants alternate IF, DM, IF...
- Wait states: mem_gnt delayed 4 cycles, then mem_rvalid 2 cycles after gnt.
  -> mem_* stable across the 4 REQ cycles; exactly one gnt and one rvalid pulse to the owner.
- Reset mid-op: rst_n low while in RSP, mem_rvalid pulsed 1 cycle after release.
  -> all outputs 0 immediately; no if_rvalid or dm_rvalid produced; FSM in IDLE.
